// File: rtl/pipeline_pkg.sv
// Shared types for the data-memory responder: RV64 load/store width
// encodings, responder FSM states and a small lane-size helper.
package pipeline_pkg;

  // funct3 width field of RV64 loads/stores; 3'b111 has no meaning.
  typedef enum logic [2:0] {
    MW_B   = 3'b000,
    MW_H   = 3'b001,
    MW_W   = 3'b010,
    MW_D   = 3'b011,
    MW_BU  = 3'b100,
    MW_HU  = 3'b101,
    MW_WU  = 3'b110,
    MW_BAD = 3'b111
  } mem_wid_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } rsp_state_e;

  localparam int CNT_W = 4;

  // Byte-lane mask of an access at offset 0, from the low two width bits.
  function automatic logic [7:0] size_mask(logic [1:0] sz);
    logic [7:0] m;
    case (sz)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_lane.sv
// Combinational byte-lane unit: store byte enables and lane placement,
// load lane extraction with sign/zero extension, alignment check.
module dmem_lane
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [2:0]            addr_lo_i,
  input  logic [2:0]            wid_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [DATA_WIDTH-1:0] rword_i,
  output logic [7:0]            be_o,
  output logic [DATA_WIDTH-1:0] wword_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  misalign_o,
  output logic                  wid_bad_o
);

  logic [7:0]            mask;
  logic [2:0]            off_mask;
  logic [5:0]            shamt;
  logic [DATA_WIDTH-1:0] rsh;

  // Lane placement, alignment and load extension for the current access.
  always_comb begin
    mask       = size_mask(wid_i[1:0]);
    // Offset bits that must be zero for a naturally aligned access.
    off_mask   = {wid_i[1:0] == 2'd3, wid_i[1], wid_i[1:0] != 2'd0};
    shamt      = {addr_lo_i, 3'b000};
    be_o       = mask << addr_lo_i;
    wword_o    = wdata_i << shamt;
    rsh        = rword_i >> shamt;
    misalign_o = |(addr_lo_i & off_mask);
    wid_bad_o  = (wid_i == MW_BAD);
    case (mem_wid_e'(wid_i))
      MW_B:    rdata_o = {{(DATA_WIDTH-8){rsh[7]}}, rsh[7:0]};
      MW_H:    rdata_o = {{(DATA_WIDTH-16){rsh[15]}}, rsh[15:0]};
      MW_W:    rdata_o = {{(DATA_WIDTH-32){rsh[31]}}, rsh[31:0]};
      MW_BU:   rdata_o = {{(DATA_WIDTH-8){1'b0}}, rsh[7:0]};
      MW_HU:   rdata_o = {{(DATA_WIDTH-16){1'b0}}, rsh[15:0]};
      MW_WU:   rdata_o = {{(DATA_WIDTH-32){1'b0}}, rsh[31:0]};
      default: rdata_o = rsh;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with programmable wait states.
// Request side: a request transfers on a cycle where req_valid_i and
// req_ready_o are both 1; response side: rsp_valid_o, rsp_rdata_o and
// rsp_err_o hold until a cycle with rsp_ready_i=1, which completes it.
module dmem_responder
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int DEPTH_DW    = 512,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [2:0]            req_wid_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic [1:0]            dbg_state_o
);

  localparam int IDX_W = $clog2(DEPTH_DW);
  localparam logic [DATA_WIDTH-1:0] ADDR_LIMIT = DATA_WIDTH'(DEPTH_DW * 8);

  rsp_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  live_q;
  logic                  accept, enter_resp, store_fire;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] addr_q, wdata_q;
  logic [2:0]            wid_q;
  logic                  cur_we;
  logic [DATA_WIDTH-1:0] cur_addr, cur_wdata;
  logic [2:0]            cur_wid;
  logic                  acc_err;
  logic [IDX_W-1:0]      idx;
  logic [7:0]            be;
  logic [DATA_WIDTH-1:0] wword, lane_rdata, rword;
  logic                  misalign, wid_bad;
  logic                  rsp_err_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH_DW];

  // Ready is held low until the first edge after reset release.
  assign req_ready_o = (state_q == ST_IDLE) && live_q;
  assign accept      = req_valid_i && req_ready_o;
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign dbg_state_o = state_q;

  // With zero wait states RESP is entered on the accept edge, so the live
  // access comes straight from the request pins while idle.
  always_comb begin
    cur_we    = we_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    cur_wid   = wid_q;
    if (state_q == ST_IDLE) begin
      cur_we    = req_we_i;
      cur_addr  = req_addr_i;
      cur_wdata = req_wdata_i;
      cur_wid   = req_wid_i;
    end
  end

  assign idx     = cur_addr[IDX_W+2:3];
  assign rword   = mem_q[idx];
  assign acc_err = misalign || wid_bad || (cur_addr >= ADDR_LIMIT);

  dmem_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
    .addr_lo_i  (cur_addr[2:0]),
    .wid_i      (cur_wid),
    .wdata_i    (cur_wdata),
    .rword_i    (rword),
    .be_o       (be),
    .wword_o    (wword),
    .rdata_o    (lane_rdata),
    .misalign_o (misalign),
    .wid_bad_o  (wid_bad)
  );

  // Next-state and wait counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES);
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);
  assign store_fire = enter_resp && cur_we && !acc_err;

  // FSM, request latch and response registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      live_q      <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wid_q       <= '0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      live_q  <= 1'b1;
      if (accept) begin
        we_q    <= req_we_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        wid_q   <= req_wid_i;
      end
      if (enter_resp) begin
        rsp_err_q   <= acc_err;
        rsp_rdata_q <= (acc_err || cur_we) ? '0 : lane_rdata;
      end
    end
  end

  // Storage is deliberately not reset; stores write only enabled lanes.
  always_ff @(posedge clk_i) begin
    if (store_fire) begin
      for (int b = 0; b < 8; b++) begin
        if (be[b]) mem_q[idx][b*8 +: 8] <= wword[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: instance 0 uses one wait state,
// instance 1 uses none.
module tb_dmem_responder;

  logic        clk;
  logic        rst_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [63:0] req_addr  [2];
  logic [63:0] req_wdata [2];
  logic [2:0]  req_wid   [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [63:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic [1:0]  dbg_state [2];

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  dmem_responder #(.DATA_WIDTH(64), .DEPTH_DW(512), .WAIT_CYCLES(1)) dut_w1 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_we_i(req_we[0]),
    .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]), .req_wid_i(req_wid[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
    .rsp_rdata_o(rsp_rdata[0]), .rsp_err_o(rsp_err[0]), .dbg_state_o(dbg_state[0])
  );

  dmem_responder #(.DATA_WIDTH(64), .DEPTH_DW(512), .WAIT_CYCLES(0)) dut_w0 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_we_i(req_we[1]),
    .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]), .req_wid_i(req_wid[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
    .rsp_rdata_o(rsp_rdata[1]), .rsp_err_o(rsp_err[1]), .dbg_state_o(dbg_state[1])
  );

  // ---------------- scoreboard ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  // One complete transaction: present at negedge, accept on the next edge,
  // wait (bounded) for the response, then complete the handshake.
  // lat = edges from the accept edge (inclusive) until rsp_valid is seen.
  task automatic do_req(input int d, input logic we, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [2:0] wid,
                        output logic [63:0] rdata, output logic err, output int lat);
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_wid[d]   = wid;
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    lat = 1;
    while (!rsp_valid[d] && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq("rsp_valid_seen", 64'(rsp_valid[d]), 64'd1);
    rdata = rsp_rdata[d];
    err   = rsp_err[d];
    rsp_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[d] = 1'b0;
  endtask

  logic [63:0] rd;
  logic        er;
  int          lat;

  // Directed vector table for instance 0: {we, addr, wdata, wid, exp_rdata, exp_err}
  typedef struct {
    string       tag;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [2:0]  wid;
    logic [63:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [$];

  initial begin
    vecs.push_back('{"st_d_10",  1'b1, 64'h10,   64'h1122334455667788, 3'b011, 64'h0, 1'b0});
    vecs.push_back('{"ld_d_10",  1'b0, 64'h10,   64'h0, 3'b011, 64'h1122334455667788, 1'b0});
    vecs.push_back('{"ld_b_17",  1'b0, 64'h17,   64'h0, 3'b000, 64'h11, 1'b0});
    vecs.push_back('{"ld_w_14",  1'b0, 64'h14,   64'h0, 3'b010, 64'h11223344, 1'b0});
    vecs.push_back('{"st_b_17",  1'b1, 64'h17,   64'hFFFF_FF80, 3'b000, 64'h0, 1'b0});
    vecs.push_back('{"ld_b_17s", 1'b0, 64'h17,   64'h0, 3'b000, 64'hFFFFFFFFFFFFFF80, 1'b0});
    vecs.push_back('{"ld_bu_17", 1'b0, 64'h17,   64'h0, 3'b100, 64'h80, 1'b0});
    vecs.push_back('{"ld_h_11",  1'b0, 64'h11,   64'h0, 3'b001, 64'h0, 1'b1});
    vecs.push_back('{"st_w_oob", 1'b1, 64'h1002, 64'hDEADBEEF, 3'b010, 64'h0, 1'b1});
    vecs.push_back('{"st_d_mis", 1'b1, 64'h14,   64'hCAFE, 3'b011, 64'h0, 1'b1});
    vecs.push_back('{"ld_wid7",  1'b0, 64'h10,   64'h0, 3'b111, 64'h0, 1'b1});
    vecs.push_back('{"ld_d_10b", 1'b0, 64'h10,   64'h0, 3'b011, 64'h8022334455667788, 1'b0});
    vecs.push_back('{"ld_hu_16", 1'b0, 64'h16,   64'h0, 3'b101, 64'h8022, 1'b0});
    vecs.push_back('{"ld_h_16",  1'b0, 64'h16,   64'h0, 3'b001, 64'hFFFFFFFFFFFF8022, 1'b0});
  end

  // ---------------- main sequence ----------------
  initial begin
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
      req_wdata[d] = '0;   req_wid[d] = 3'b011; rsp_ready[d] = 1'b0;
    end
    rst_n = 1'b0;
    #3;
    check_eq("rst_ready",  64'(req_ready[0]), 64'd0);
    check_eq("rst_valid",  64'(rsp_valid[0]), 64'd0);
    check_eq("rst_rdata",  rsp_rdata[0], 64'd0);
    check_eq("rst_err",    64'(rsp_err[0]), 64'd0);
    check_eq("rst_state",  64'(dbg_state[0]), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("ready_after_rst", 64'(req_ready[0]), 64'd1);

    // Directed vectors on the one-wait-state instance.
    foreach (vecs[i]) begin
      do_req(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wid, rd, er, lat);
      check_eq({vecs[i].tag, "_rdata"}, rd, vecs[i].exp_rd);
      check_eq({vecs[i].tag, "_err"}, 64'(er), 64'(vecs[i].exp_err));
      check_eq({vecs[i].tag, "_lat"}, 64'(lat), 64'd2);
    end

    // Response back-pressure with a pending request held on the pins.
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 64'h10; req_wid[0] = 3'b011;
    @(posedge clk);
    #1;
    req_addr[0] = 64'h17; req_wid[0] = 3'b100;
    lat = 1;
    while (!rsp_valid[0] && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq("bp_lat", 64'(lat), 64'd2);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check_eq("bp_valid", 64'(rsp_valid[0]), 64'd1);
      check_eq("bp_rdata", rsp_rdata[0], 64'h8022334455667788);
      check_eq("bp_err",   64'(rsp_err[0]), 64'd0);
      check_eq("bp_ready", 64'(req_ready[0]), 64'd0);
    end
    @(negedge clk);
    rsp_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[0] = 1'b0;
    check_eq("bp_idle_ready", 64'(req_ready[0]), 64'd1);
    check_eq("bp_idle_valid", 64'(rsp_valid[0]), 64'd0);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    check_eq("bp_pend_state", 64'(dbg_state[0]), 64'd1);
    @(posedge clk);
    #1;
    check_eq("bp_pend_valid", 64'(rsp_valid[0]), 64'd1);
    check_eq("bp_pend_rdata", rsp_rdata[0], 64'h80);
    rsp_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[0] = 1'b0;

    // Reset during the wait state of a store abandons it.
    do_req(0, 1'b1, 64'h20, 64'h5555, 3'b011, rd, er, lat);
    check_eq("pre_st_err", 64'(er), 64'd0);
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 64'h20;
    req_wdata[0] = 64'hAA; req_wid[0] = 3'b011;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    check_eq("mid_state_wait", 64'(dbg_state[0]), 64'd1);
    rst_n = 1'b0;
    #2;
    check_eq("mid_rst_valid", 64'(rsp_valid[0]), 64'd0);
    check_eq("mid_rst_rdata", rsp_rdata[0], 64'd0);
    check_eq("mid_rst_err",   64'(rsp_err[0]), 64'd0);
    check_eq("mid_rst_ready", 64'(req_ready[0]), 64'd0);
    check_eq("mid_rst_state", 64'(dbg_state[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("post_rst_ready", 64'(req_ready[0]), 64'd1);
    do_req(0, 1'b0, 64'h20, 64'h0, 3'b011, rd, er, lat);
    check_eq("post_rst_ld", rd, 64'h5555);

    // Zero-wait-state instance: single latency then streaming loads.
    do_req(1, 1'b1, 64'h0, 64'h0123456789ABCDEF, 3'b011, rd, er, lat);
    check_eq("w0_st0_lat", 64'(lat), 64'd1);
    do_req(1, 1'b1, 64'h8, 64'hFEDCBA9876543210, 3'b011, rd, er, lat);
    check_eq("w0_st8_err", 64'(er), 64'd0);
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 64'h0; req_wid[1] = 3'b011;
    rsp_ready[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check_eq("w0_bb_valid", 64'(rsp_valid[1]), 64'd1);
      check_eq("w0_bb_rdata", rsp_rdata[1],
               (k % 2 == 0) ? 64'h0123456789ABCDEF : 64'hFEDCBA9876543210);
      req_addr[1] = (k % 2 == 0) ? 64'h8 : 64'h0;
      @(posedge clk);
      #1;
      check_eq("w0_bb_gap",   64'(rsp_valid[1]), 64'd0);
      check_eq("w0_bb_ready", 64'(req_ready[1]), 64'd1);
    end
    req_valid[1] = 1'b0;
    rsp_ready[1] = 1'b0;
    @(posedge clk);
    #1;
    check_eq("w0_end_idle", 64'(rsp_valid[1]), 64'd0);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
